// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter built from a chain of T flip-flop cells.
// Each cell toggles when its t_vec bit is set; terminal states force the wrap toggles.
module tff_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] dn_chain;
  logic [WIDTH-1:0] t_step;
  logic [WIDTH-1:0] load_val;
  logic             wrap_reg;

  // Ripple AND of the lower bits: a bit toggles once everything below it
  // is all ones (counting up) or all zeros (counting down).
  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign up_chain[gi] = up_chain[gi-1] & q_reg[gi-1];
      assign dn_chain[gi] = dn_chain[gi-1] & ~q_reg[gi-1];
    end
  endgenerate

  assign tc = up ? (q_reg == MAX) : (q_reg == '0);

  always_comb begin
    t_step = up ? up_chain : dn_chain;
    if (tc) begin
      t_step = up ? q_reg : MAX;
    end
  end

  // Only toggles that actually land on q are reported.
  assign t_vec = (en && !load && !rst) ? t_step : '0;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tcell
      assign q_next[gi] = q_reg[gi] ^ t_vec[gi];
    end
  endgenerate

  assign load_val = (din > MAX) ? MAX : din;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
    end else if (load) begin
      q_reg    <= load_val;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= en & tc;
    end
  end

  assign q    = q_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter: a MOD=10 instance and a full-range MOD=16 instance.
module tb_tff_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] din;
  logic [3:0] q, t_vec;
  logic       tc, wrap;

  logic       rst16, en16, up16, load16;
  logic [3:0] din16;
  logic [3:0] q16, t_vec16;
  logic       tc16, wrap16;

  int n_cmp = 0;
  int n_bad = 0;
  int e, e_prev;

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q), .t_vec(t_vec), .tc(tc), .wrap(wrap)
  );

  tff_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
    .clk(clk), .rst(rst16), .en(en16), .up(up16), .load(load16), .din(din16),
    .q(q16), .t_vec(t_vec16), .tc(tc16), .wrap(wrap16)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one edge, then settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en = 0; up = 1; load = 0; din = 0;
    rst16 = 1; en16 = 0; up16 = 1; load16 = 0; din16 = 0;
    #2;
    step();
    check("rst_q", 32'(q), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_tc_up", 32'(tc), 0);
    up = 0; #1;
    check("rst_tc_dn", 32'(tc), 1);

    // Up count 12 cycles: 0..9,0,1,2
    rst = 0; en = 1; up = 1; e = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("up_tc", 32'(tc), (e == 9) ? 1 : 0);
      check("up_tvec", 32'(t_vec), (e == 9) ? e : ((e ^ (e + 1)) & 15));
      e_prev = e;
      step();
      e = (e == 9) ? 0 : e + 1;
      check("up_q", 32'(q), e);
      check("up_wrap", 32'(wrap), (e_prev == 9) ? 1 : 0);
    end

    // Load 5 then count down 7 cycles: 4,3,2,1,0,9,8
    en = 0; load = 1; din = 5;
    step();
    check("ld5_q", 32'(q), 5);
    check("ld5_wrap", 32'(wrap), 0);
    load = 0; up = 0; en = 1; e = 5;
    for (int k = 0; k < 7; k++) begin
      #1;
      check("dn_tc", 32'(tc), (e == 0) ? 1 : 0);
      check("dn_tvec", 32'(t_vec), (e == 0) ? 9 : ((e ^ (e - 1)) & 15));
      e_prev = e;
      step();
      e = (e == 0) ? 9 : e - 1;
      check("dn_q", 32'(q), e);
      check("dn_wrap", 32'(wrap), (e_prev == 0) ? 1 : 0);
    end

    // Saturating load, then wrap from 9
    en = 0; load = 1; din = 13;
    step();
    check("sat_q", 32'(q), 9);
    check("sat_wrap", 32'(wrap), 0);
    load = 0; en = 1; up = 1; #1;
    check("sat_tvec", 32'(t_vec), 9);
    step();
    check("sat_step_q", 32'(q), 0);
    check("sat_step_wrap", 32'(wrap), 1);

    // load beats en; rst beats load
    en = 0; load = 1; din = 7;
    step();
    check("ld7_q", 32'(q), 7);
    en = 1; load = 1; din = 2;
    step();
    check("ld_en_q", 32'(q), 2);
    check("ld_en_wrap", 32'(wrap), 0);
    rst = 1; load = 1; din = 4;
    step();
    check("rst_ld_q", 32'(q), 0);

    // Reset mid-count at terminal suppresses wrap
    rst = 0; en = 0; load = 1; din = 9;
    step();
    load = 0; en = 1; up = 1; rst = 1;
    step();
    check("rst9_q", 32'(q), 0);
    check("rst9_wrap", 32'(wrap), 0);

    // Hold with en=0
    rst = 0; en = 0; load = 1; din = 6;
    step();
    load = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_tvec", 32'(t_vec), 0);
      step();
      check("hold_q", 32'(q), 6);
      check("hold_wrap", 32'(wrap), 0);
    end

    // Full-range modulus
    step();
    rst16 = 0; load16 = 1; din16 = 7;
    step();
    check("m16_ld7_q", 32'(q16), 7);
    load16 = 0; en16 = 1; up16 = 1; #1;
    check("m16_tvec7", 32'(t_vec16), 15);
    step();
    check("m16_q8", 32'(q16), 8);
    en16 = 0; load16 = 1; din16 = 15;
    step();
    load16 = 0; en16 = 1; up16 = 1; #1;
    check("m16_tc15", 32'(tc16), 1);
    step();
    check("m16_wrap_up_q", 32'(q16), 0);
    check("m16_wrap_up", 32'(wrap16), 1);
    up16 = 0; #1;
    check("m16_tc0", 32'(tc16), 1);
    check("m16_tvec0", 32'(t_vec16), 15);
    step();
    check("m16_wrap_dn_q", 32'(q16), 15);
    check("m16_wrap_dn", 32'(wrap16), 1);
    en16 = 0;
    step();
    check("m16_wrap_clr", 32'(wrap16), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_mod_counter.md
Name: tff_mod_counter

Overview:
- Synchronous modulo-N up/down counter built as a chain of T flip-flop cells. Each bit's toggle input is derived from the state of the lower bits.
- Consumes the toggle behaviour of the flip-flop conversion stage. It is the next block up the sequential hierarchy: it drives per-bit toggle enables and produces a count, a terminal-count flag and a wrap pulse.
- Used as a divider/event counter in downstream sequential blocks.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MOD, 10, count modulus; legal range 2..2^WIDTH. Count sequence is 0..MOD-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count (registered).
- t_vec  output  WIDTH  per-bit toggle enables applied this cycle (combinational, for observability).
- tc  output  1  terminal count: high when q==MOD-1 and up=1, or when q==0 and up=0 (combinational from q and up).
- wrap  output  1  registered one-cycle pulse, asserted the cycle after the count wrapped.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-high, sampled on the clk rising edge.
- Priority per edge: rst > load > en. With en=0 and no load, q holds and t_vec=0.
- Reset:
  - q=0 and wrap=0 on the edge where rst=1.
  - tc after reset follows the rule: 0 if up=1 (with MOD>1), 1 if up=0.
  - Reset mid-count clears immediately; an in-flight wrap pulse is suppressed.
- Load:
  - q <= din when din <= MOD-1.
  - din > MOD-1 saturates, so q <= MOD-1.
  - wrap <= 0 on a load edge.
  - load overrides en.
- Counting, in T flip-flop form. Each bit i is a T cell: q[i] <= q[i] ^ t_vec[i].
  - Up, not at terminal: t_vec[0]=1; t_vec[i]=&q[i-1:0].
  - Down, not at terminal: t_vec[0]=1; t_vec[i]=&(~q[i-1:0]).
  - Up at q==MOD-1: t_vec = q, so every set bit toggles to reach 0.
  - Down at q==0: t_vec = MOD-1, so the count reaches MOD-1.
  - When MOD==2^WIDTH the natural binary wrap and the terminal rule give the same result.
- Latency:
  - q updates on the same edge en is sampled, one step per enabled cycle.
  - No internal pipeline; back-to-back steps every cycle.
- wrap:
  - Set to 1 on the edge where en=1 and tc=1 (load=0, rst=0).
  - Cleared on every other edge, so the pulse is exactly one cycle wide.
  - Consecutive wraps are impossible for MOD>=2 unless direction flips. For example, up at MOD-1 wraps to 0; switching to down at 0 wraps again on the next edge. In that case wrap stays high for two cycles, which is legal.
- Direction change:
  - up is sampled per edge; it may change any cycle.
  - tc and t_vec reflect the current up value combinationally.
- Simultaneous events:
  - load+en: load wins; no step, no wrap.
  - rst+load: reset wins.
- No illegal states reachable once MOD constraints hold. If q is forced to a value >= MOD, an up count steps naturally until the binary wrap, with no correction; the bench does not test this.

Test Plan:
- Reset, then en=1 up=1 for 12 cycles (WIDTH=4, MOD=10) -> q: 0,1,..,9,0,1,2. tc=1 only while q=9. wrap=1 exactly in the cycle q first reads 0 after 9.
- Load din=5, then up=0 en=1 for 7 cycles -> q: 5,4,3,2,1,0,9,8. tc=1 while q=0. wrap pulses once after the 0->9 transition.
- Load din=13 (> MOD-1) -> q=9 next cycle, wrap=0. One enabled up step -> q=0, wrap=1.
- At q=7 assert load=1 din=2 together with en=1 -> q=2, no step. Same cycle, rst=1 with load=1 din=4 -> q=0.
- Reset mid-count at q=9 with en=1 up=1 -> q=0, wrap stays 0. At q=6 with en=0 -> q holds 6 and t_vec=0 for 5 cycles.
- MOD=16, WIDTH=4: at q=7 up step -> t_vec=4'b1111, q=8. Up from 15 -> q=0, wrap=1. Down from 0 -> q=15, wrap=1.
